pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Front-end pipeline sequencer that consumes the `stall` decision from the hazard unit and applies it. It holds the PC and the F→D, D→E and E→M instruction/PC registers. It freezes F and D, and injects a NOP bubble into E, on every stalled cycle. It also applies branch/jump redirects resolved in D, with MIPS delay-slot semantics. Its `ir_D`, `ir_E` and `ir_M` outputs feed back into the hazard unit's instruction inputs, closing the stall loop.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `CNT_W`, default 32: width of the stall-cycle counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  freeze request from the hazard unit for the current cycle.
- `instr_F`  in  32  instruction fetched at `pc_F` (combinational IM read).
- `redirect_D`  in  1  branch taken / jump in D this cycle.
- `target_D`  in  32  redirect target; bits [1:0] ignored, treated as 0.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `pc_F`  out  32  fetch PC.
- `ir_D`, `pc_D`  out  32 each  D-stage instruction and its PC.
- `ir_E`, `pc_E`  out  32 each  E-stage instruction and its PC.
- `ir_M`, `pc_M`  out  32 each  M-stage instruction and its PC.
- `bubble_E`  out  1  E currently holds an injected bubble.
- `stall_cnt`  out  CNT_W  number of stalled cycles, saturating.

## Operation
- Reset (`rst_n`=0, asynchronous): `pc_F`=RESET_PC; `ir_D`, `pc_D`, `ir_E`, `pc_E`, `ir_M`, `pc_M`=0; `bubble_E`=0; `stall_cnt`=0.
- Normal cycle (`stall`=0):
  - `pc_F` ← `redirect_D` ? {`target_D`[31:2],2'b00} : `pc_F`+4. Addition is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - `ir_D`←`instr_F`, `pc_D`←`pc_F`.
  - `ir_E`←`ir_D`, `pc_E`←`pc_D`, `bubble_E`←0.
- Stall cycle (`stall`=1):
  - `pc_F`, `ir_D`, `pc_D` hold.
  - `ir_E`←0 (sll $0 NOP), `pc_E`←0, `bubble_E`←1.
  - `redirect_D` and `target_D` are ignored. A stalled branch re-evaluates on the release cycle.
- E→M always advances, regardless of `stall`: `ir_M`←`ir_E`, `pc_M`←`pc_E`.
- Delay slot: no flush on redirect. The instruction fetched in the redirect cycle (`pc_D`+4) enters D normally.
- Consecutive stalls: each stalled cycle injects one more bubble. D holds indefinitely until `stall` drops.
- `stall_cnt` (only when the counter is compiled in):
  - `cnt_clr`=1 → 0 (clear wins over increment in the same cycle).
  - Else if `stall`=1 and not all-ones → +1.
  - Saturates at 2^CNT_W−1.

## Timing
- Fully registered outputs. No combinational path from any input to any output.
- `stall` sampled at edge N: the effect is visible after edge N; the D instruction reissues to E at edge N+1 if `stall` is low then.
- Redirect latency is one cycle: `redirect_D` at edge N gives `pc_F`=target after edge N.
- An `rst_n` assertion mid-stall or mid-redirect clears all state immediately. The first fetch after deassertion is RESET_PC.

## Configuration
- `PIPE_STALL_CNT_EN` defined: `stall_cnt` register and `cnt_clr` logic are present as above.
- Not defined: `stall_cnt` is tied to 0, `cnt_clr` is ignored, and no counter flops are built.

## Test plan
- Reset: hold `rst_n`=0, then release → `pc_F`=32'h3000. After 3 edges with `stall`=0, `pc_F`=32'h300C, `pc_D`=32'h3008, `pc_E`=32'h3004, `pc_M`=32'h3000.
- Single stall: with `ir_D`=32'h0085_3020 at `pc_D`=32'h3008, assert `stall` for 1 cycle.
  - After that edge: `ir_D` and `pc_F` unchanged; `ir_E`=0, `bubble_E`=1.
  - Next edge: `ir_E`=32'h0085_3020, `bubble_E`=0.
- Redirect with delay slot: `pc_F`=32'h3010, `redirect_D`=1, `target_D`=32'h3043. After the edge, `pc_F`=32'h3040 and `pc_D`=32'h3010 (delay slot kept).
- Redirect under stall: `stall`=1, `redirect_D`=1, `target_D`=32'h4000 → `pc_F` holds. Next cycle with `stall`=0, `redirect_D`=1 → `pc_F`=32'h4000.
- PC wrap: `target_D`=32'hFFFF_FFFC, then one normal cycle → `pc_F`=0.
- Counter (macro defined, CNT_W=2): 5 stall cycles → `stall_cnt`=3 (saturated). Then `cnt_clr`=1 together with `stall`=1 → 0. Without the macro, `stall_cnt` stays 0 throughout.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// ============================================================================
// pipe_stall_ctrl
// ----------------------------------------------------------------------------
// Front-end pipeline sequencer. Holds the fetch PC and the F->D, D->E and
// E->M instruction/PC registers. It applies the hazard unit's stall decision
// in three ways on a stalled cycle:
//   - F and D are frozen.
//   - A NOP bubble is injected into E.
//   - E->M still advances.
// Branch/jump redirects resolved in D are applied with MIPS delay-slot
// semantics, so the instruction behind the branch is never flushed.
//
// Configuration macro:
//   PIPE_STALL_CNT_EN - when defined, builds a saturating stall-cycle counter
//                       with a synchronous clear. When undefined, stall_cnt is
//                       tied to 0 and cnt_clr is ignored.
//
// Ports:
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   stall       in   freeze request for the current cycle
//   instr_F     in   instruction fetched at pc_F
//   redirect_D  in   branch taken / jump in D
//   target_D    in   redirect target (bits [1:0] treated as 0)
//   cnt_clr     in   synchronous clear of stall_cnt
//   pc_F        out  fetch PC
//   ir_D, pc_D  out  D-stage instruction / PC
//   ir_E, pc_E  out  E-stage instruction / PC
//   ir_M, pc_M  out  M-stage instruction / PC
//   bubble_E    out  E holds an injected bubble
//   stall_cnt   out  saturating count of stalled cycles
// ============================================================================
module pipe_stall_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [31:0]      instr_F,
    input  logic             redirect_D,
    input  logic [31:0]      target_D,
    input  logic             cnt_clr,
    output logic [31:0]      pc_F,
    output logic [31:0]      ir_D,
    output logic [31:0]      pc_D,
    output logic [31:0]      ir_E,
    output logic [31:0]      pc_E,
    output logic [31:0]      ir_M,
    output logic [31:0]      pc_M,
    output logic             bubble_E,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0] pcF_q, pcF_d;
    logic [31:0] irD_q, irD_d;
    logic [31:0] pcD_q, pcD_d;
    logic [31:0] irE_q, irE_d;
    logic [31:0] pcE_q, pcE_d;
    logic [31:0] irM_q, irM_d;
    logic [31:0] pcM_q, pcM_d;
    logic        bubbleE_q, bubbleE_d;

    // Next-state logic for the pipeline registers. A stall freezes F and D
    // and turns E into a NOP bubble. M always takes whatever E held, so a
    // bubble drains forward naturally. Redirects are ignored while stalled;
    // the branch is still in D and re-evaluates on the release cycle.
    always_comb begin
        pcF_d     = pcF_q;
        irD_d     = irD_q;
        pcD_d     = pcD_q;
        irE_d     = 32'h0;
        pcE_d     = 32'h0;
        bubbleE_d = 1'b1;
        irM_d     = irE_q;
        pcM_d     = pcE_q;
        if (!stall) begin
            // No flush on redirect: the delay-slot fetch still enters D.
            pcF_d     = redirect_D ? {target_D[31:2], 2'b00} : pcF_q + 32'd4;
            irD_d     = instr_F;
            pcD_d     = pcF_q;
            irE_d     = irD_q;
            pcE_d     = pcD_q;
            bubbleE_d = 1'b0;
        end
    end

    // Pipeline state registers with asynchronous reset to the boot PC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcF_q     <= RESET_PC;
            irD_q     <= 32'h0;
            pcD_q     <= 32'h0;
            irE_q     <= 32'h0;
            pcE_q     <= 32'h0;
            irM_q     <= 32'h0;
            pcM_q     <= 32'h0;
            bubbleE_q <= 1'b0;
        end else begin
            pcF_q     <= pcF_d;
            irD_q     <= irD_d;
            pcD_q     <= pcD_d;
            irE_q     <= irE_d;
            pcE_q     <= pcE_d;
            irM_q     <= irM_d;
            pcM_q     <= pcM_d;
            bubbleE_q <= bubbleE_d;
        end
    end

    assign pc_F     = pcF_q;
    assign ir_D     = irD_q;
    assign pc_D     = pcD_q;
    assign ir_E     = irE_q;
    assign pc_E     = pcE_q;
    assign ir_M     = irM_q;
    assign pc_M     = pcM_q;
    assign bubble_E = bubbleE_q;

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic             unusedBits;

    // Stall counter next state: clear has priority over counting, and the
    // count sticks at all-ones instead of wrapping.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (cnt_clr) begin
            stallCnt_d = '0;
        end else if (stall && !(&stallCnt_q)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign stall_cnt  = stallCnt_q;
    assign unusedBits = ^target_D[1:0];
`else
    logic unusedBits;

    assign stall_cnt  = '0;
    assign unusedBits = ^{target_D[1:0], cnt_clr};
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ============================================================================
// tb_pipe_stall_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for pipe_stall_ctrl. Each stimulus step drives one
// cycle of inputs and pushes the hand-computed post-edge state into a
// scoreboard queue. A monitor pops one entry per falling edge and compares it
// against the DUT outputs. The DUT is built with CNT_W=2 so that counter
// saturation is reachable. Expected counter values depend on whether
// PIPE_STALL_CNT_EN is defined.
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int CNT_W = 2;
`ifdef PIPE_STALL_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] pcF;
        logic [31:0] pcD;
        logic [31:0] irD;
        logic [31:0] pcE;
        logic [31:0] irE;
        logic [31:0] pcM;
        logic [31:0] irM;
        logic        bub;
        logic [1:0]  cnt;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             stall;
    logic [31:0]      instr_F;
    logic             redirect_D;
    logic [31:0]      target_D;
    logic             cnt_clr;
    logic [31:0]      pc_F;
    logic [31:0]      ir_D;
    logic [31:0]      pc_D;
    logic [31:0]      ir_E;
    logic [31:0]      pc_E;
    logic [31:0]      ir_M;
    logic [31:0]      pc_M;
    logic             bubble_E;
    logic [CNT_W-1:0] stall_cnt;

    exp_t scoreQ[$];
    int   passCount = 0;
    int   totalCount = 0;

    pipe_stall_ctrl #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .instr_F    (instr_F),
        .redirect_D (redirect_D),
        .target_D   (target_D),
        .cnt_clr    (cnt_clr),
        .pc_F       (pc_F),
        .ir_D       (ir_D),
        .pc_D       (pc_D),
        .ir_E       (ir_E),
        .pc_E       (pc_E),
        .ir_M       (ir_M),
        .pc_M       (pc_M),
        .bubble_E   (bubble_E),
        .stall_cnt  (stall_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: one recognisable word at 0x3008 and a PC-tagged
    // pattern everywhere else, so every fetched word identifies its address.
    function automatic logic [31:0] im(input logic [31:0] pc);
        if (pc == 32'h0000_3008) return 32'h0085_3020;
        return 32'hAA00_0000 ^ pc;
    endfunction

    assign instr_F = im(pc_F);

    function automatic exp_t mk(input string n,
                                input logic [31:0] pcF, pcD, irD, pcE, irE,
                                pcM, irM,
                                input logic bub, input logic [1:0] cnt);
        exp_t e;
        e.name = n; e.pcF = pcF; e.pcD = pcD; e.irD = irD;
        e.pcE = pcE; e.irE = irE; e.pcM = pcM; e.irM = irM;
        e.bub = bub; e.cnt = CntEn ? cnt : 2'd0;
        return e;
    endfunction

    task automatic chk(input string n, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s.%s actual=%h required=%h", n, field, act, exp);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        chk(e.name, "pc_F", pc_F, e.pcF);
        chk(e.name, "pc_D", pc_D, e.pcD);
        chk(e.name, "ir_D", ir_D, e.irD);
        chk(e.name, "pc_E", pc_E, e.pcE);
        chk(e.name, "ir_E", ir_E, e.irE);
        chk(e.name, "pc_M", pc_M, e.pcM);
        chk(e.name, "ir_M", ir_M, e.irM);
        chk(e.name, "bubble_E", {31'h0, bubble_E}, {31'h0, e.bub});
        chk(e.name, "stall_cnt", {30'h0, stall_cnt}, {30'h0, e.cnt});
    endtask

    // Drive one cycle of inputs just after the falling edge and queue the
    // state expected after the next rising edge.
    task automatic applyStimulus(input logic rstN, input logic st,
                                 input logic rd, input logic [31:0] tgt,
                                 input logic clr, input exp_t e);
        @(negedge clk);
        #1;
        rst_n      = rstN;
        stall      = st;
        redirect_D = rd;
        target_D   = tgt;
        cnt_clr    = clr;
        scoreQ.push_back(e);
    endtask

    // Monitor: one queued expectation is due at each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect_D = 1'b0;
        target_D = 32'h0; cnt_clr = 1'b0;

        applyStimulus(0, 0, 0, 32'h0, 0,
            mk("reset", 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 32'h0, 0,
            mk("run1", 32'h3004, 32'h3000, im(32'h3000), 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 32'h0, 0,
            mk("run2", 32'h3008, 32'h3004, im(32'h3004), 32'h3000, im(32'h3000),
               0, 0, 0, 0));
        applyStimulus(1, 0, 0, 32'h0, 0,
            mk("run3", 32'h300C, 32'h3008, 32'h0085_3020, 32'h3004, im(32'h3004),
               32'h3000, im(32'h3000), 0, 0));
        applyStimulus(1, 1, 0, 32'h0, 0,
            mk("stall1", 32'h300C, 32'h3008, 32'h0085_3020, 0, 0,
               32'h3004, im(32'h3004), 1, 1));
        applyStimulus(1, 0, 0, 32'h0, 0,
            mk("release1", 32'h3010, 32'h300C, im(32'h300C), 32'h3008, 32'h0085_3020,
               0, 0, 0, 1));
        applyStimulus(1, 0, 1, 32'h3043, 0,
            mk("redirect", 32'h3040, 32'h3010, im(32'h3010), 32'h300C, im(32'h300C),
               32'h3008, 32'h0085_3020, 0, 1));
        applyStimulus(1, 1, 1, 32'h4000, 0,
            mk("redirStall", 32'h3040, 32'h3010, im(32'h3010), 0, 0,
               32'h300C, im(32'h300C), 1, 2));
        applyStimulus(1, 0, 1, 32'h4000, 0,
            mk("redirRelease", 32'h4000, 32'h3040, im(32'h3040), 32'h3010, im(32'h3010),
               0, 0, 0, 2));
        applyStimulus(1, 0, 1, 32'hFFFF_FFFF, 0,
            mk("toTop", 32'hFFFF_FFFC, 32'h4000, im(32'h4000), 32'h3040, im(32'h3040),
               32'h3010, im(32'h3010), 0, 2));
        applyStimulus(1, 0, 0, 32'h0, 0,
            mk("wrap", 32'h0, 32'hFFFF_FFFC, im(32'hFFFF_FFFC), 32'h4000, im(32'h4000),
               32'h3040, im(32'h3040), 0, 2));
        applyStimulus(1, 0, 0, 32'h0, 1,
            mk("clr", 32'h4, 32'h0, im(32'h0), 32'hFFFF_FFFC, im(32'hFFFF_FFFC),
               32'h4000, im(32'h4000), 0, 0));
        applyStimulus(1, 1, 0, 32'h0, 0,
            mk("sat1", 32'h4, 32'h0, im(32'h0), 0, 0,
               32'hFFFF_FFFC, im(32'hFFFF_FFFC), 1, 1));
        applyStimulus(1, 1, 0, 32'h0, 0,
            mk("sat2", 32'h4, 32'h0, im(32'h0), 0, 0, 0, 0, 1, 2));
        applyStimulus(1, 1, 0, 32'h0, 0,
            mk("sat3", 32'h4, 32'h0, im(32'h0), 0, 0, 0, 0, 1, 3));
        applyStimulus(1, 1, 0, 32'h0, 0,
            mk("sat4", 32'h4, 32'h0, im(32'h0), 0, 0, 0, 0, 1, 3));
        applyStimulus(1, 1, 0, 32'h0, 0,
            mk("sat5", 32'h4, 32'h0, im(32'h0), 0, 0, 0, 0, 1, 3));
        applyStimulus(1, 1, 0, 32'h0, 1,
            mk("clrWins", 32'h4, 32'h0, im(32'h0), 0, 0, 0, 0, 1, 0));
        applyStimulus(1, 0, 0, 32'h0, 0,
            mk("release2", 32'h8, 32'h4, im(32'h4), 32'h0, im(32'h0), 0, 0, 0, 0));
        applyStimulus(1, 1, 0, 32'h0, 0,
            mk("stall3", 32'h8, 32'h4, im(32'h4), 0, 0, 32'h0, im(32'h0), 1, 1));
        applyStimulus(0, 1, 1, 32'h5000, 0,
            mk("midReset", 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0));
        applyStimulus(1, 0, 0, 32'h0, 0,
            mk("afterReset", 32'h3004, 32'h3000, im(32'h3000), 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        #2;
        totalCount++;
        if (scoreQ.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL drain actual=%0d required=0 pending entries",
                     scoreQ.size());
        end
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
